// File: rtl/i2c_role_arbiter.sv
// Role arbiter between the I2C master and slave engines: tracks bus state from the
// synchronised pads, commits role changes only on an idle bus, and muxes the active engine out.
module i2c_role_arbiter #(
   parameter int unsigned BUS_IDLE_CYCLES = 64
) (
   input  logic       i_clk,
   input  logic       i_n_rst,
   input  logic       i_ms_select_req,
   input  logic       i_sda_sync,
   input  logic       i_scl_sync,
   input  logic       i_busy_master,
   input  logic       i_busy_slave,
   input  logic       i_sda_out_master,
   input  logic       i_sda_out_slave,
   input  logic       i_scl_out_master,
   input  logic       i_scl_out_slave,
   input  logic       i_tx_read_enable_master,
   input  logic       i_tx_read_enable_slave,
   input  logic       i_rx_write_enable_master,
   input  logic       i_rx_write_enable_slave,
   input  logic [7:0] i_rx_data_master,
   input  logic [7:0] i_rx_data_slave,
   input  logic       i_set_transaction_complete_master,
   input  logic       i_set_transaction_complete_slave,
   input  logic       i_ack_error_set_master,
   input  logic       i_ack_error_set_slave,
   output logic       o_ms_select,
   output logic       o_sda_out,
   output logic       o_scl_out,
   output logic       o_tx_read_enable,
   output logic       o_rx_write_enable,
   output logic [7:0] o_rx_data,
   output logic       o_set_transaction_complete,
   output logic       o_ack_error_set,
   output logic       o_bus_busy,
   output logic       o_switch_pending
);

   localparam int unsigned CntW = $clog2(BUS_IDLE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(BUS_IDLE_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StBusy   = 2'd1,
      StSwitch = 2'd2
   } state_e;

   state_e          r_state;
   state_e          w_state_next;
   logic            r_sda_q;
   logic            r_scl_q;
   logic [CntW-1:0] r_idle_cnt;
   logic [CntW-1:0] w_idle_cnt_next;
   logic            r_ms_select;
   logic            w_ms_select_next;
   logic            r_bus_busy;

   logic            w_start;
   logic            w_stop;
   logic            w_timeout;
   logic            w_switch_ok;
   logic            w_sel;

   logic            r_sda_out;
   logic            r_scl_out;
   logic            r_tx_re;
   logic            r_rx_we;
   logic [7:0]      r_rx_data;
   logic            r_tc;
   logic            r_ack;
   logic            w_sda_out_next;
   logic            w_scl_out_next;
   logic            w_tx_re_next;
   logic            w_rx_we_next;
   logic [7:0]      w_rx_data_next;
   logic            w_tc_next;
   logic            w_ack_next;

   assign w_start     = r_scl_q & i_scl_sync & r_sda_q & ~i_sda_sync;
   assign w_stop      = r_scl_q & i_scl_sync & ~r_sda_q & i_sda_sync;
   assign w_timeout   = (r_idle_cnt == CntMax);
   assign w_switch_ok = o_switch_pending & ~i_busy_master & ~i_busy_slave;

   // State, edge-detect history, idle counter and committed role
   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         r_state     <= StIdle;
         r_sda_q     <= 1'b1;
         r_scl_q     <= 1'b1;
         r_idle_cnt  <= '0;
         r_ms_select <= 1'b0;
         r_bus_busy  <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_sda_q     <= i_sda_sync;
         r_scl_q     <= i_scl_sync;
         r_idle_cnt  <= w_idle_cnt_next;
         r_ms_select <= w_ms_select_next;
         r_bus_busy  <= (w_state_next == StBusy);
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_start) begin
               w_state_next = StBusy;
            end else if (w_switch_ok) begin
               w_state_next = StSwitch;
            end
         end
         StBusy: begin
            if (w_stop || w_timeout) begin
               w_state_next = StIdle;
            end
         end
         StSwitch: begin
            w_state_next = w_start ? StBusy : StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      w_idle_cnt_next = '0;
      if ((r_state == StBusy) && (w_state_next == StBusy) && i_sda_sync && i_scl_sync) begin
         w_idle_cnt_next = w_timeout ? r_idle_cnt : r_idle_cnt + 1'b1;
      end
   end

   // Select follows the role being committed so the first post-switch cycle uses the new engine
   always_comb begin
      w_sel            = (r_state == StSwitch) ? i_ms_select_req : r_ms_select;
      w_ms_select_next = w_sel;
      w_sda_out_next   = w_sel ? i_sda_out_master : i_sda_out_slave;
      w_scl_out_next   = w_sel ? i_scl_out_master : i_scl_out_slave;
      w_tx_re_next     = w_sel ? i_tx_read_enable_master : i_tx_read_enable_slave;
      w_rx_we_next     = w_sel ? i_rx_write_enable_master : i_rx_write_enable_slave;
      w_rx_data_next   = w_sel ? i_rx_data_master : i_rx_data_slave;
      w_tc_next        = w_sel ? i_set_transaction_complete_master
                               : i_set_transaction_complete_slave;
      w_ack_next       = w_sel ? i_ack_error_set_master : i_ack_error_set_slave;
      if (w_state_next == StSwitch) begin
         w_sda_out_next = 1'b1;
         w_scl_out_next = 1'b1;
         w_tx_re_next   = 1'b0;
         w_rx_we_next   = 1'b0;
         w_rx_data_next = r_rx_data;
         w_tc_next      = 1'b0;
         w_ack_next     = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         r_sda_out <= 1'b1;
         r_scl_out <= 1'b1;
         r_tx_re   <= 1'b0;
         r_rx_we   <= 1'b0;
         r_rx_data <= 8'h00;
         r_tc      <= 1'b0;
         r_ack     <= 1'b0;
      end else begin
         r_sda_out <= w_sda_out_next;
         r_scl_out <= w_scl_out_next;
         r_tx_re   <= w_tx_re_next;
         r_rx_we   <= w_rx_we_next;
         r_rx_data <= w_rx_data_next;
         r_tc      <= w_tc_next;
         r_ack     <= w_ack_next;
      end
   end

   assign o_ms_select                = r_ms_select;
   assign o_sda_out                  = r_sda_out;
   assign o_scl_out                  = r_scl_out;
   assign o_tx_read_enable           = r_tx_re;
   assign o_rx_write_enable          = r_rx_we;
   assign o_rx_data                  = r_rx_data;
   assign o_set_transaction_complete = r_tc;
   assign o_ack_error_set            = r_ack;
   assign o_bus_busy                 = r_bus_busy;
   assign o_switch_pending           = r_ms_select ^ i_ms_select_req;

endmodule
